// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: two requesters share one font ROM, A has priority, B is starvation-protected.
// Latency: grant in cycle c -> rom_rd in c+1 -> valid_x in c+2+ROM_LAT, fixed regardless of load.
// Backpressure: gnt_x is combinational; a requester holds req_x until granted, dropping it cancels.
module font_rom_arbiter #(
  parameter int ROM_LAT      = 1,  // legal 1..4
  parameter int STARVE_LIMIT = 8   // legal 1..15
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        req_a,
  input  logic [10:0] offset_a,
  input  logic [5:0]  idx_a,
  output logic        gnt_a,
  output logic        valid_a,
  output logic [7:0]  data_a,
  input  logic        req_b,
  input  logic [10:0] offset_b,
  input  logic [5:0]  idx_b,
  output logic        gnt_b,
  output logic        valid_b,
  output logic [7:0]  data_b,
  output logic [10:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  output logic [1:0]  arb_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERV_A  = 2'd1,
    SERV_B  = 2'd2,
    FORCE_B = 2'd3
  } arb_state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [3:0]       starve_q, starve_d;
  logic [10:0]      addr_q, addr_d;
  logic             gnt_a_d, gnt_b_d, xfer;
  // Stage 0 lines up with rom_rd, stage ROM_LAT with valid rom_data.
  logic [ROM_LAT:0] pvld_q, pown_q;
  logic             valid_a_q, valid_b_q;
  logic [7:0]       data_a_q, data_b_q;

  // Grant selection: starved B first, then A, then B; nothing while in reset.
  always_comb begin
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    state_d = IDLE;
    if (!reset) begin
      if (req_b && (starve_q == STARVE_MAX)) begin
        gnt_b_d = 1'b1;
        state_d = FORCE_B;
      end else if (req_a) begin
        gnt_a_d = 1'b1;
        state_d = SERV_A;
      end else if (req_b) begin
        gnt_b_d = 1'b1;
        state_d = SERV_B;
      end
    end
  end

  assign xfer = gnt_a_d | gnt_b_d;

  // Starvation count and next ROM address; address wraps naturally at 11 bits.
  always_comb begin
    starve_d = starve_q;
    if (gnt_b_d || !req_b) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
    addr_d = addr_q;
    if (gnt_b_d) begin
      addr_d = offset_b + {5'b0, idx_b};
    end else if (gnt_a_d) begin
      addr_d = offset_a + {5'b0, idx_a};
    end
  end

  // Arbiter state, counter, address and response capture.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      addr_q    <= 11'd0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      data_a_q  <= 8'd0;
      data_b_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      valid_a_q <= pvld_q[ROM_LAT] & ~pown_q[ROM_LAT];
      valid_b_q <= pvld_q[ROM_LAT] & pown_q[ROM_LAT];
      if (pvld_q[ROM_LAT] && !pown_q[ROM_LAT]) begin
        data_a_q <= rom_data;
      end
      if (pvld_q[ROM_LAT] && pown_q[ROM_LAT]) begin
        data_b_q <= rom_data;
      end
    end
  end

  // Owner tag shift pipeline; reset drops every read still in flight.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      pvld_q <= '0;
      pown_q <= '0;
    end else begin
      pvld_q <= {pvld_q[ROM_LAT-1:0], xfer};
      pown_q <= {pown_q[ROM_LAT-1:0], gnt_b_d};
    end
  end

  assign gnt_a       = gnt_a_d;
  assign gnt_b       = gnt_b_d;
  assign rom_addr    = addr_q;
  assign rom_rd      = pvld_q[0];
  assign valid_a     = valid_a_q;
  assign valid_b     = valid_b_q;
  assign data_a      = data_a_q;
  assign data_b      = data_b_q;
  assign arb_state_o = state_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: three instances (ROM_LAT 1, 2, 4) share stimulus.
// Instance 0 is tracked cycle by cycle against a transaction-level reference model.
// The other two are used for the latency sweep and reset flush checks.
`timescale 1ns/1ps
module tb_font_rom_arbiter;

  localparam int LIMIT = 8;
  localparam logic [1:0] ST_SERV_A  = 2'd1;
  localparam logic [1:0] ST_FORCE_B = 2'd3;

  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [10:0] offset_a = '0, offset_b = '0;
  logic [5:0]  idx_a = '0, idx_b = '0;

  logic        gnt_a_w [3];
  logic        gnt_b_w [3];
  logic        valid_a_w [3];
  logic        valid_b_w [3];
  logic        rom_rd_w [3];
  logic [7:0]  data_a_w [3];
  logic [7:0]  data_b_w [3];
  logic [7:0]  rom_data_w [3];
  logic [10:0] rom_addr_w [3];
  logic [1:0]  state_w [3];

  logic [7:0]  rom_mem [2048];

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [10:0] dly [4];
    // ROM model: data for the address read in cycle n appears in cycle n+L
    always @(posedge clk_50MHz) begin
      dly[0] <= rom_addr_w[g];
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end
    assign rom_data_w[g] = rom_mem[dly[L-1]];

    font_rom_arbiter #(.ROM_LAT(L), .STARVE_LIMIT(LIMIT)) u_dut (
      .clk_50MHz  (clk_50MHz),
      .reset      (reset),
      .req_a      (req_a),
      .offset_a   (offset_a),
      .idx_a      (idx_a),
      .gnt_a      (gnt_a_w[g]),
      .valid_a    (valid_a_w[g]),
      .data_a     (data_a_w[g]),
      .req_b      (req_b),
      .offset_b   (offset_b),
      .idx_b      (idx_b),
      .gnt_b      (gnt_b_w[g]),
      .valid_b    (valid_b_w[g]),
      .data_b     (data_b_w[g]),
      .rom_addr   (rom_addr_w[g]),
      .rom_rd     (rom_rd_w[g]),
      .rom_data   (rom_data_w[g]),
      .arb_state_o(state_w[g])
    );
  end

  // ---------------- reference model (ROM_LAT = 1) ----------------
  typedef struct {
    bit         own_b;
    logic [7:0] dat;
    int         due;
  } resp_t;

  resp_t       pend [$];
  int          checks = 0, failures = 0;
  int          cyc = 0, m_cnt = 0;
  logic        obs_ga, obs_gb, exp_ga, exp_gb;
  logic        exp_rd = 1'b0, exp_va = 1'b0, exp_vb = 1'b0;
  logic [10:0] exp_addr = '0;
  logic [7:0]  exp_da = '0, exp_db = '0;
  logic [31:0] got_v, want_v;

  // Advance one clock: predict grant, sample DUT grant, update the model at the edge.
  task automatic tick();
    resp_t r;
    int    a;
    exp_gb = !reset && req_b && (m_cnt == LIMIT || !req_a);
    exp_ga = !reset && req_a && !exp_gb;
    @(negedge clk_50MHz);
    obs_ga = gnt_a_w[0];
    obs_gb = gnt_b_w[0];
    @(posedge clk_50MHz);
    cyc++;
    if (reset) begin
      m_cnt = 0; exp_rd = 0; exp_addr = '0; exp_va = 0; exp_vb = 0;
      exp_da = '0; exp_db = '0;
      pend.delete();
    end else begin
      exp_va = 0; exp_vb = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.own_b) begin exp_vb = 1; exp_db = r.dat; end
        else begin exp_va = 1; exp_da = r.dat; end
      end
      if (exp_ga || exp_gb) begin
        a = exp_gb ? (int'(offset_b) + int'(idx_b)) % 2048 : (int'(offset_a) + int'(idx_a)) % 2048;
        exp_addr = 11'(a);
        exp_rd = 1;
        pend.push_back('{own_b: exp_gb, dat: rom_mem[a], due: cyc + 2});
      end else begin
        exp_rd = 0;
      end
      m_cnt = (exp_gb || !req_b) ? 0 : ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT);
    end
    #1;
    got_v  = {obs_ga, obs_gb, rom_rd_w[0], rom_addr_w[0], valid_a_w[0], valid_b_w[0], data_a_w[0], data_b_w[0]};
    want_v = {exp_ga, exp_gb, exp_rd, exp_addr, exp_va, exp_vb, exp_da, exp_db};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'($urandom_range(0, 1)); req_b = 1'($urandom_range(0, 1));
      offset_a = 11'($urandom); offset_b = 11'($urandom);
      tick();
      checks++;
      if (got_v !== 32'h0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc, got_v, 32'h0);
      end
    end
  endtask

  task automatic test_single_read();
    logic [7:0] want;
    int lat;
    reset = 0; req_a = 0; req_b = 0;
    tick(); tick();
    req_a = 1; offset_a = 11'h280; idx_a = 6'h05;
    tick();
    checks++;
    if (obs_ga !== 1'b1 || obs_gb !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt got a=%b b=%b want a=1 b=0", obs_ga, obs_gb);
    end
    checks++;
    if (rom_addr_w[0] !== 11'h285 || rom_rd_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_addr got addr=%h rd=%b want addr=285 rd=1", rom_addr_w[0], rom_rd_w[0]);
    end
    req_a = 0;
    want = rom_mem[11'h285];
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        lat = lat_of(g);
        checks++;
        if (valid_a_w[g] !== (k == lat + 1) || valid_b_w[g] !== 1'b0) begin
          failures++;
          $display("FAIL latency lat=%0d k=%0d got va=%b vb=%b want va=%b vb=0",
                   lat, k, valid_a_w[g], valid_b_w[g], (k == lat + 1));
        end
        if (k == lat + 1) begin
          checks++;
          if (data_a_w[g] !== want) begin
            failures++;
            $display("FAIL single_data lat=%0d got=%h want=%h", lat, data_a_w[g], want);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    req_a = 0; req_b = 1; offset_b = 11'h7C0; idx_b = 6'h3F;
    tick();
    checks++;
    if (obs_gb !== 1'b1 || rom_addr_w[0] !== 11'h7FF || rom_rd_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_7ff got gb=%b addr=%h rd=%b want gb=1 addr=7ff rd=1", obs_gb, rom_addr_w[0], rom_rd_w[0]);
    end
    offset_b = 11'h7FF; idx_b = 6'h01;
    tick();
    checks++;
    if (obs_gb !== 1'b1 || rom_addr_w[0] !== 11'h000 || rom_rd_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_000 got gb=%b addr=%h rd=%b want gb=1 addr=000 rd=1", obs_gb, rom_addr_w[0], rom_rd_w[0]);
    end
    req_b = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL wrap_drain cyc=%0d got=%h want=%h", cyc, got_v, want_v);
      end
    end
  endtask

  task automatic test_starvation();
    logic bexp;
    req_a = 0; req_b = 0;
    tick();
    req_a = 1; req_b = 1;
    for (int i = 0; i < 27; i++) begin
      offset_a = 11'($urandom); idx_a = 6'($urandom);
      offset_b = 11'($urandom); idx_b = 6'($urandom);
      tick();
      bexp = ((i + 1) % 9 == 0);
      checks++;
      if (obs_gb !== bexp || obs_ga !== !bexp) begin
        failures++;
        $display("FAIL starve_gnt i=%0d got a=%b b=%b want a=%b b=%b", i, obs_ga, obs_gb, !bexp, bexp);
      end
      checks++;
      if (state_w[0] !== (bexp ? ST_FORCE_B : ST_SERV_A)) begin
        failures++;
        $display("FAIL starve_state i=%0d got=%0d want=%0d", i, state_w[0], bexp ? ST_FORCE_B : ST_SERV_A);
      end
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL starve_model cyc=%0d got=%h want=%h", cyc, got_v, want_v);
      end
    end
    req_a = 0; req_b = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL starve_drain cyc=%0d got=%h want=%h", cyc, got_v, want_v);
      end
    end
  endtask

  task automatic test_stream();
    int   base, nvalid;
    logic conc;
    base = int'($urandom_range(0, 31));
    nvalid = 0; conc = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        req_a = (i % 2 == 0); req_b = (i % 2 != 0);
        offset_a = 11'(((base + i) % 32) * 64); offset_b = offset_a;
        idx_a = 6'($urandom); idx_b = 6'($urandom);
      end else begin
        req_a = 0; req_b = 0;
      end
      tick();
      if (i < 20) begin
        checks++;
        if (obs_ga !== req_a || obs_gb !== req_b) begin
          failures++;
          $display("FAIL stream_gnt i=%0d got a=%b b=%b want a=%b b=%b", i, obs_ga, obs_gb, req_a, req_b);
        end
      end
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL stream_model cyc=%0d got=%h want=%h", cyc, got_v, want_v);
      end
      if (valid_a_w[0] === 1'b1) nvalid++;
      if (valid_b_w[0] === 1'b1) nvalid++;
      if (valid_a_w[0] === 1'b1 && valid_b_w[0] === 1'b1) conc = 1;
    end
    checks++;
    if (nvalid != 20) begin
      failures++;
      $display("FAIL stream_count got=%0d want=20", nvalid);
    end
    checks++;
    if (conc !== 1'b0) begin
      failures++;
      $display("FAIL stream_concurrent got=%b want=0", conc);
    end
  endtask

  task automatic test_reset_midflight();
    logic [10:0] na;
    int lat;
    reset = 0; req_a = 0; req_b = 0;
    tick();
    req_a = 1; offset_a = 11'($urandom); idx_a = 6'($urandom);
    tick();
    req_a = 0; req_b = 1; offset_b = 11'($urandom); idx_b = 6'($urandom);
    tick();
    reset = 1; req_a = 1; req_b = 1;
    tick();
    checks++;
    if (obs_ga !== 1'b0 || obs_gb !== 1'b0) begin
      failures++;
      $display("FAIL rst_gnt got a=%b b=%b want 0 0", obs_ga, obs_gb);
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rom_rd_w[g] !== 1'b0 || valid_a_w[g] !== 1'b0 || valid_b_w[g] !== 1'b0 ||
          rom_addr_w[g] !== 11'h0 || data_a_w[g] !== 8'h0 || data_b_w[g] !== 8'h0) begin
        failures++;
        $display("FAIL rst_outputs g=%0d got rd=%b va=%b vb=%b addr=%h da=%h db=%h want all zero",
                 g, rom_rd_w[g], valid_a_w[g], valid_b_w[g], rom_addr_w[g], data_a_w[g], data_b_w[g]);
      end
    end
    // first cycle with reset low already carries a new request
    reset = 0; req_b = 0; req_a = 1;
    offset_a = 11'($urandom); idx_a = 6'($urandom);
    na = 11'((int'(offset_a) + int'(idx_a)) % 2048);
    tick();
    checks++;
    if (obs_ga !== 1'b1 || rom_addr_w[0] !== na) begin
      failures++;
      $display("FAIL rst_first_gnt got ga=%b addr=%h want ga=1 addr=%h", obs_ga, rom_addr_w[0], na);
    end
    req_a = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        lat = lat_of(g);
        checks++;
        if (valid_a_w[g] !== (k == lat + 1) || valid_b_w[g] !== 1'b0) begin
          failures++;
          $display("FAIL rst_flush lat=%0d k=%0d got va=%b vb=%b want va=%b vb=0",
                   lat, k, valid_a_w[g], valid_b_w[g], (k == lat + 1));
        end
        if (k == lat + 1) begin
          checks++;
          if (data_a_w[g] !== rom_mem[na]) begin
            failures++;
            $display("FAIL rst_new_data lat=%0d got=%h want=%h", lat, data_a_w[g], rom_mem[na]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int pa, pb;
    for (int i = 0; i < 404; i++) begin
      if (i < 400) begin
        pa = (i < 200) ? 90 : 50;
        pb = (i < 200) ? 75 : 50;
        reset = ($urandom_range(0, 59) == 0);
        req_a = ($urandom_range(0, 99) < pa);
        req_b = ($urandom_range(0, 99) < pb);
        offset_a = 11'($urandom); idx_a = 6'($urandom);
        offset_b = 11'($urandom); idx_b = 6'($urandom);
      end else begin
        reset = 0; req_a = 0; req_b = 0;
      end
      tick();
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_v, want_v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    test_reset();
    test_single_read();
    test_wrap();
    test_starvation();
    test_stream();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
